measurement_sequencer: RTL

MEASUREMENT_SEQUENCER -- requirements
Module: measurement_sequencer

---
 rtl/measurement_pkg.sv | 21 ++
 rtl/meas_timeout_counter.sv | 32 +++
 rtl/measurement_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/measurement_pkg.sv
// Shared types and field positions for the measurement sequencer and its detector config word.
package measurement_pkg;

  localparam int unsigned PERIODS_LSB    = 0;
  localparam int unsigned PERIODS_WIDTH  = 8;
  localparam int unsigned FILTER_RST_BIT = 31;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    ARM     = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // A request for zero periods means a single period.
  function automatic logic [PERIODS_WIDTH-1:0] norm_periods(input logic [PERIODS_WIDTH-1:0] p);
    return (p == '0) ? PERIODS_WIDTH'(1) : p;
  endfunction

endpackage

// File: rtl/meas_timeout_counter.sv
// Cycle counter for the ARM/MEASURE window; expired flags the last allowed cycle.
module meas_timeout_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [WIDTH-1:0] count;
  logic [EXT_W-1:0] count_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // Extra bit keeps the compare correct at the top of the count range.
  assign count_inc = EXT_W'(count) + EXT_W'(1);
  assign expired   = enable && (limit != '0) && (count_inc >= EXT_W'(limit));

endmodule

// File: rtl/measurement_sequencer.sv
// Sequences a zero-crossing detector: filter flush, arm, integration window, result capture, timeout.
module measurement_sequencer
  import measurement_pkg::*;
#(
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_start,
  input  logic                   ctrl_continuous,
  input  logic                   ctrl_abort,
  input  logic [7:0]             ctrl_periods,
  input  logic [REG_WIDTH-1:0]   timeout_limit,
  output logic [REG_WIDTH-1:0]   zcd_config,
  input  logic                   zcd_data_valid,
  input  logic [REG_WIDTH-1:0]   zcd_number_samples,
  input  logic                   zcd_int_start,
  input  logic                   zcd_int_stop,
  output logic                   integ_enable,
  output logic                   result_valid,
  output logic [REG_WIDTH-1:0]   result_samples,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   busy,
  output logic                   irq,
  input  logic                   irq_ack,
  output logic                   status_timeout
);

  localparam int unsigned FLUSH_LAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam int unsigned FLUSH_W    = (FLUSH_LAST > 0) ? $clog2(FLUSH_LAST + 1) : 1;
  localparam logic [REG_WIDTH-1:0] CFG_RESET =
    (REG_WIDTH'(1) << FILTER_RST_BIT) | REG_WIDTH'(1);

  state_t                 state, state_next;
  logic [FLUSH_W-1:0]     flush_cnt, flush_next;
  logic [REG_WIDTH-1:0]   cfg_next;
  logic [REG_WIDTH-1:0]   samples_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   integ_next, rv_next, irq_next, to_next, busy_next;
  logic                   capture, to_set, to_clr;
  logic                   in_window, expired;

  assign in_window = (state == ARM) || (state == MEASURE);

  meas_timeout_counter #(
    .WIDTH (REG_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_window),
    .enable  (in_window),
    .limit   (timeout_limit),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      zcd_config     <= CFG_RESET;
      integ_enable   <= 1'b0;
      result_valid   <= 1'b0;
      result_samples <= '0;
      result_count   <= '0;
      busy           <= 1'b0;
      irq            <= 1'b0;
      status_timeout <= 1'b0;
    end else begin
      state          <= state_next;
      flush_cnt      <= flush_next;
      zcd_config     <= cfg_next;
      integ_enable   <= integ_next;
      result_valid   <= rv_next;
      result_samples <= samples_next;
      result_count   <= count_next;
      busy           <= busy_next;
      irq            <= irq_next;
      status_timeout <= to_next;
    end
  end

  always_comb begin
    state_next   = state;
    flush_next   = '0;
    cfg_next     = zcd_config;
    integ_next   = integ_enable;
    rv_next      = 1'b0;
    samples_next = result_samples;
    count_next   = result_count;
    capture      = 1'b0;
    to_set       = 1'b0;
    to_clr       = 1'b0;

    case (state)
      IDLE: begin
        if (ctrl_start) begin
          state_next = FLUSH;
          cfg_next[PERIODS_LSB +: PERIODS_WIDTH] = norm_periods(ctrl_periods);
          to_clr = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_W'(FLUSH_LAST)) begin
          state_next = ARM;
        end else begin
          flush_next = flush_cnt + FLUSH_W'(1);
        end
      end
      ARM: begin
        if (expired) begin
          state_next = IDLE;
          to_set     = 1'b1;
        end else if (zcd_int_start && zcd_data_valid) begin
          state_next = DONE;
          capture    = 1'b1;
        end else if (zcd_int_start) begin
          state_next = MEASURE;
          integ_next = 1'b1;
        end
      end
      MEASURE: begin
        if (expired) begin
          state_next = IDLE;
          to_set     = 1'b1;
        end else if (zcd_data_valid) begin
          state_next = DONE;
          capture    = 1'b1;
        end else if (zcd_int_stop) begin
          integ_next = 1'b0;
        end
      end
      DONE: begin
        state_next = ctrl_continuous ? ARM : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides everything, including a start or a result in the same cycle.
    if (ctrl_abort) begin
      state_next = IDLE;
      flush_next = '0;
      cfg_next   = zcd_config;
      capture    = 1'b0;
      to_set     = 1'b0;
      to_clr     = 1'b0;
    end

    if (capture) begin
      rv_next      = 1'b1;
      samples_next = zcd_number_samples;
      count_next   = result_count + COUNT_WIDTH'(1);
    end

    if (state_next != MEASURE) begin
      integ_next = 1'b0;
    end

    cfg_next[FILTER_RST_BIT] = (state_next == IDLE) || (state_next == FLUSH);
    busy_next = (state_next != IDLE);

    // Sticky flags: a new set wins over an acknowledge in the same cycle.
    irq_next = (capture || to_set) ? 1'b1 : (irq_ack ? 1'b0 : irq);
    to_next  = to_set ? 1'b1 : ((irq_ack || to_clr) ? 1'b0 : status_timeout);
  end

endmodule
